// File: rtl/systolic_job_sequencer.sv
// systolic_job_sequencer
//   Runs one matrix-tile job on a 1xN output-stationary systolic array.
//   After a start it clears the accumulators once, then runs cfg_passes
//   K-chunk passes. Each pass is a weight load, an activation stream and a
//   pipeline drain. Finally it settles the outputs and pulses done.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start, abort          job request (accepted in IDLE only) / cancel job
//   cfg_passes            number of K-chunk passes (0 = clear only)
//   cfg_shift             result right-shift amount, latched on start
//   cfg_act_base/wet_base buffer start addresses, latched on start
//   buf_ready             buffers hold data for the next pass
//   busy, done            job in progress / one-cycle completion pulse
//   act_rd_en/addr        activation buffer read strobe and address
//   wet_rd_en/addr        weight buffer read strobe and address
//   PE_*                  array control pins
//
// Every output is a flop loaded from the decode of the next state, so the
// outputs line up with the state register without any combinational path.
// In IDLE all outputs except PE_res_shift_num are 0.
module systolic_job_sequencer #(
  parameter int BN_NUM   = 10,
  parameter int ACCU_NUM = 5,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_passes,
  input  logic [7:0]        cfg_shift,
  input  logic [ADDR_W-1:0] cfg_act_base,
  input  logic [ADDR_W-1:0] cfg_wet_base,
  input  logic              buf_ready,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              wet_rd_en,
  output logic [ADDR_W-1:0] wet_rd_addr,
  output logic              PE_clear_acc,
  output logic              PE_mac_enable,
  output logic              PE_weight_partial_sel,
  output logic [7:0]        PE_res_shift_num
);

  localparam int DRAIN_LEN = ACCU_NUM + BN_NUM + 2;
  localparam int PH_W      = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GAP, S_LOAD_W, S_STREAM, S_DRAIN, S_FIN, S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [PH_W-1:0]   phase_cnt_reg;
  logic [CNT_W-1:0]  pass_cnt_reg;
  logic [CNT_W-1:0]  passes_reg;
  logic              accept;
  logic              last_pass;
  state_t            pass_entry;

  logic busy_next, done_next, act_en_next, wet_en_next;
  logic clear_next, mac_next, sel_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = (state_reg == S_IDLE) && start && !abort;
    // pass_cnt_reg counts finished passes; compare before it increments so
    // a pass count of 2^CNT_W-1 never needs a wider counter.
    last_pass  = (CNT_W'(pass_cnt_reg + 1'b1) == passes_reg);
    // A pass entry with data already available skips the GAP state entirely,
    // so back-to-back passes cost no idle cycle.
    pass_entry = buf_ready ? S_LOAD_W : S_GAP;

    case (state_reg)
      S_IDLE:   if (accept) state_next = S_CLEAR;
      S_CLEAR:  state_next = (passes_reg == '0) ? S_FIN : pass_entry;
      S_GAP:    if (buf_ready) state_next = S_LOAD_W;
      S_LOAD_W: if (phase_cnt_reg == PH_W'(ACCU_NUM - 1)) state_next = S_STREAM;
      S_STREAM: if (phase_cnt_reg == PH_W'(BN_NUM - 1)) state_next = S_DRAIN;
      S_DRAIN:  if (phase_cnt_reg == PH_W'(DRAIN_LEN - 1))
                  state_next = last_pass ? S_FIN : pass_entry;
      S_FIN:    if (phase_cnt_reg == PH_W'(1)) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    if (abort && (state_reg != S_IDLE)) state_next = S_IDLE;

    busy_next   = (state_next != S_IDLE);
    done_next   = (state_next == S_DONE);
    clear_next  = (state_next == S_CLEAR);
    act_en_next = (state_next == S_STREAM);
    wet_en_next = (state_next == S_LOAD_W) || (state_next == S_STREAM);
    mac_next    = (state_next == S_LOAD_W) || (state_next == S_STREAM) ||
                  (state_next == S_DRAIN);
    sel_next    = (state_next == S_STREAM) || (state_next == S_DRAIN);
  end

  // Phase timer, pass counter and latched job configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt_reg    <= '0;
      pass_cnt_reg     <= '0;
      passes_reg       <= '0;
      PE_res_shift_num <= '0;
    end else begin
      phase_cnt_reg <= (state_next != state_reg) ? '0 : phase_cnt_reg + 1'b1;
      if (state_next == S_IDLE) begin
        pass_cnt_reg <= '0;
      end else if ((state_reg == S_DRAIN) && (state_next != S_DRAIN)) begin
        pass_cnt_reg <= pass_cnt_reg + 1'b1;
      end
      if (accept) begin
        passes_reg       <= cfg_passes;
        PE_res_shift_num <= cfg_shift;
      end
    end
  end

  // Registered outputs. Addresses advance after each strobed cycle and wrap
  // naturally; they persist across passes and return to 0 in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy                  <= 1'b0;
      done                  <= 1'b0;
      act_rd_en             <= 1'b0;
      wet_rd_en             <= 1'b0;
      PE_clear_acc          <= 1'b0;
      PE_mac_enable         <= 1'b0;
      PE_weight_partial_sel <= 1'b0;
      act_rd_addr           <= '0;
      wet_rd_addr           <= '0;
    end else begin
      busy                  <= busy_next;
      done                  <= done_next;
      act_rd_en             <= act_en_next;
      wet_rd_en             <= wet_en_next;
      PE_clear_acc          <= clear_next;
      PE_mac_enable         <= mac_next;
      PE_weight_partial_sel <= sel_next;
      if (state_next == S_IDLE) begin
        act_rd_addr <= '0;
        wet_rd_addr <= '0;
      end else if (accept) begin
        act_rd_addr <= cfg_act_base;
        wet_rd_addr <= cfg_wet_base;
      end else begin
        if (act_rd_en) act_rd_addr <= act_rd_addr + 1'b1;
        if (wet_rd_en) wet_rd_addr <= wet_rd_addr + 1'b1;
      end
    end
  end

endmodule
